// File: rtl/mux_scan_nx1.sv
`default_nettype none
// ============================================================================
//  Module   : mux_scan_nx1
//  Purpose  : N-channel, W-bit registered mux with direct select and an
//             optional round-robin auto-scan mode (enabled by MUX_SCAN_EN).
//  Revision : 1.0  initial release
// ============================================================================
module mux_scan_nx1 #(
    parameter int NCH   = 16,
    parameter int W     = 1,
    parameter int SW    = $clog2(NCH),
    parameter int DWELL = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH*W-1:0]   i,
    input  logic [SW-1:0]      s,
    input  logic               mode,
    input  logic               en,
    input  logic [NCH-1:0]     ch_mask,
    output logic [W-1:0]       y,
    output logic [SW-1:0]      y_ch,
    output logic               y_valid,
    output logic               wrap
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic [SW:0] c_nch = (SW+1)'(NCH);

    state_t         r_state, w_state_nxt;
    logic [W-1:0]   r_y, w_y_nxt;
    logic [SW-1:0]  r_y_ch, w_y_ch_nxt;
    logic           r_y_valid, w_y_valid_nxt;
    logic           r_wrap, w_wrap_nxt;

    function automatic logic [W-1:0] f_pick(input logic [NCH*W-1:0] data,
                                            input logic [SW-1:0]    idx);
        logic [W-1:0] sel;
        sel = '0;
        for (int k = 0; k < NCH; k++) begin
            if (idx == SW'(k)) sel = data[k*W +: W];
        end
        return sel;
    endfunction

`ifdef MUX_SCAN_EN
    localparam logic [7:0] c_dwell_last = 8'(DWELL - 1);

    logic [SW-1:0]  r_ptr, w_ptr_nxt;
    logic [7:0]     r_dwell, w_dwell_nxt;
    logic           r_wrapped, w_wrapped_nxt;
    logic           r_empty, w_empty_nxt;
    logic [SW-1:0]  w_lo, w_above;
    logic           w_lo_ok, w_above_ok;

    // Lowest enabled channel, and lowest enabled channel above the pointer.
    always_comb begin
        w_lo       = '0;
        w_lo_ok    = 1'b0;
        w_above    = '0;
        w_above_ok = 1'b0;
        for (int k = NCH-1; k >= 0; k--) begin
            if (ch_mask[k]) begin
                w_lo    = SW'(k);
                w_lo_ok = 1'b1;
                if (SW'(k) > r_ptr) begin
                    w_above    = SW'(k);
                    w_above_ok = 1'b1;
                end
            end
        end
    end
`else
    localparam int c_unused_dwell = DWELL;
    logic [NCH+2:0] w_unused_bits;
    assign w_unused_bits = {ch_mask, mode, r_state};
`endif

    always_comb begin
        w_state_nxt   = IDLE;
        w_y_nxt       = r_y;
        w_y_ch_nxt    = r_y_ch;
        w_y_valid_nxt = 1'b0;
        w_wrap_nxt    = 1'b0;
`ifdef MUX_SCAN_EN
        w_ptr_nxt     = '0;
        w_dwell_nxt   = '0;
        w_wrapped_nxt = 1'b0;
        w_empty_nxt   = 1'b0;
`endif
        if (!en) begin
            w_state_nxt = IDLE;
`ifdef MUX_SCAN_EN
        end else if (mode) begin
            w_state_nxt = SCAN;
            if (r_state != SCAN || r_empty || !w_lo_ok) begin
                // (Re)start the scan; with no channel enabled the pointer waits.
                w_ptr_nxt   = w_lo_ok ? w_lo : r_ptr;
                w_empty_nxt = !w_lo_ok;
            end else begin
                w_y_nxt       = f_pick(i, r_ptr);
                w_y_ch_nxt    = r_ptr;
                w_y_valid_nxt = ch_mask[r_ptr];
                w_wrap_nxt    = r_wrapped;
                if (!ch_mask[r_ptr] || r_dwell == c_dwell_last) begin
                    w_ptr_nxt     = w_above_ok ? w_above : w_lo;
                    w_wrapped_nxt = !w_above_ok;
                end else begin
                    w_ptr_nxt   = r_ptr;
                    w_dwell_nxt = r_dwell + 8'd1;
                end
            end
`endif
        end else begin
            w_state_nxt = DIRECT;
            w_y_ch_nxt  = s;
            if ({1'b0, s} < c_nch) begin
                w_y_nxt       = f_pick(i, s);
                w_y_valid_nxt = 1'b1;
            end else begin
                w_y_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_y       <= '0;
            r_y_ch    <= '0;
            r_y_valid <= 1'b0;
            r_wrap    <= 1'b0;
`ifdef MUX_SCAN_EN
            r_ptr     <= '0;
            r_dwell   <= '0;
            r_wrapped <= 1'b0;
            r_empty   <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_y       <= w_y_nxt;
            r_y_ch    <= w_y_ch_nxt;
            r_y_valid <= w_y_valid_nxt;
            r_wrap    <= w_wrap_nxt;
`ifdef MUX_SCAN_EN
            r_ptr     <= w_ptr_nxt;
            r_dwell   <= w_dwell_nxt;
            r_wrapped <= w_wrapped_nxt;
            r_empty   <= w_empty_nxt;
`endif
        end
    end

    assign y       = r_y;
    assign y_ch    = r_y_ch;
    assign y_valid = r_y_valid;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_nx1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_scan_nx1
//  Purpose  : Self-checking bench for mux_scan_nx1 (vector tables, hand
//             sequences and a randomized run against a behavioural model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_scan_nx1;

    localparam int A_DWELL = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A: 16 x 1, DWELL=2
    logic [15:0] a_i;  logic [3:0] a_s;  logic a_mode, a_en;  logic [15:0] a_mask;
    logic a_y;  logic [3:0] a_ych;  logic a_v, a_wrap;
    // DUT B: 16 x 1, DWELL=4
    logic [15:0] b_i;  logic [3:0] b_s;  logic b_mode, b_en;  logic [15:0] b_mask;
    logic b_y;  logic [3:0] b_ych;  logic b_v, b_wrap;
    // DUT C: 5 x 8
    logic [39:0] c_i;  logic [2:0] c_s;  logic c_mode, c_en;  logic [4:0] c_mask;
    logic [7:0] c_y;  logic [2:0] c_ych;  logic c_v, c_wrap;

    mux_scan_nx1 #(.NCH(16), .W(1), .DWELL(2)) u_a (
        .clk(clk), .rst(rst), .i(a_i), .s(a_s), .mode(a_mode), .en(a_en), .ch_mask(a_mask),
        .y(a_y), .y_ch(a_ych), .y_valid(a_v), .wrap(a_wrap));
    mux_scan_nx1 #(.NCH(16), .W(1), .DWELL(4)) u_b (
        .clk(clk), .rst(rst), .i(b_i), .s(b_s), .mode(b_mode), .en(b_en), .ch_mask(b_mask),
        .y(b_y), .y_ch(b_ych), .y_valid(b_v), .wrap(b_wrap));
    mux_scan_nx1 #(.NCH(5), .W(8), .DWELL(1)) u_c (
        .clk(clk), .rst(rst), .i(c_i), .s(c_s), .mode(c_mode), .en(c_en), .ch_mask(c_mask),
        .y(c_y), .y_ch(c_ych), .y_valid(c_v), .wrap(c_wrap));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model of DUT A: scan order taken from the list of enabled channels.
    int   m_st, m_ptr, m_cnt;
    bit   m_hold, m_wpend;
    logic m_y, m_v, m_w;
    logic [3:0] m_ych;

    task automatic model_reset();
        m_st = 0; m_ptr = 0; m_cnt = 0; m_hold = 0; m_wpend = 0;
        m_y = 0; m_ych = 0; m_v = 0; m_w = 0;
    endtask

    task automatic model_step();
        int q[$];
        int later[$];
        bit scan_req;
        m_v = 0;
        m_w = 0;
`ifdef MUX_SCAN_EN
        scan_req = a_mode;
`else
        scan_req = 0;
`endif
        for (int k = 0; k < 16; k++) if (a_mask[k]) q.push_back(k);
        if (!a_en) begin
            m_st = 0; m_wpend = 0; m_hold = 0;
        end else if (!scan_req) begin
            m_st = 1; m_y = a_i[a_s]; m_ych = a_s; m_v = 1; m_wpend = 0; m_hold = 0;
        end else if (m_st != 2 || m_hold || q.size() == 0) begin
            m_st = 2; m_wpend = 0; m_cnt = 0;
            m_hold = (q.size() == 0);
            if (!m_hold) m_ptr = q[0];
        end else begin
            m_y = a_i[m_ptr]; m_ych = 4'(m_ptr); m_v = a_mask[m_ptr];
            m_w = m_wpend; m_wpend = 0;
            m_cnt++;
            if (!a_mask[m_ptr] || m_cnt == A_DWELL) begin
                later = q.find_first with (item > m_ptr);
                m_cnt = 0;
                if (later.size() > 0) m_ptr = later[0];
                else begin m_ptr = q[0]; m_wpend = 1; end
            end
        end
    endtask

    typedef struct {
        logic [2:0] s;
        logic       en;
        logic [7:0] y;
        logic [2:0] ych;
        logic       v;
    } cvec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cvec_t cv[8];
        logic  sweep_y[16];
        int    sc_ych[10];
        int    sc_wrap[10];
        bit    found;
        cv[0] = '{3'd4, 1'b1, 8'hA1, 3'd4, 1'b1};
        cv[1] = '{3'd6, 1'b1, 8'h00, 3'd6, 1'b0};
        cv[2] = '{3'd0, 1'b1, 8'hE5, 3'd0, 1'b1};
        cv[3] = '{3'd5, 1'b1, 8'h00, 3'd5, 1'b0};
        cv[4] = '{3'd2, 1'b1, 8'hC3, 3'd2, 1'b1};
        cv[5] = '{3'd1, 1'b0, 8'hC3, 3'd2, 1'b0};
        cv[6] = '{3'd7, 1'b1, 8'h00, 3'd7, 1'b0};
        cv[7] = '{3'd3, 1'b1, 8'hB2, 3'd3, 1'b1};
        sweep_y = '{0,1,1,0,1,1,1,1,0,0,1,0,1,1,0,1};
        sc_ych  = '{0,0,2,2,0,0,2,2,0,0};
        sc_wrap = '{0,0,0,0,1,0,0,0,1,0};

        rst = 1'b1;
        a_i = '0; a_s = '0; a_mode = 0; a_en = 0; a_mask = '0;
        b_i = '0; b_s = '0; b_mode = 0; b_en = 0; b_mask = '0;
        c_i = 40'hA1B2C3D4E5; c_s = '0; c_mode = 0; c_en = 0; c_mask = '1;
        #12;
        chk("reset_y", a_y, 0);
        chk("reset_ych", a_ych, 0);
        chk("reset_valid", a_v, 0);
        chk("reset_wrap", a_wrap, 0);
        rst = 1'b0;

        // Direct sweep
        a_en = 1; a_mode = 0; a_i = 16'hB4F6;
        for (int n = 0; n < 16; n++) begin
            a_s = 4'(n);
            tick();
            chk("sweep_y", a_y, sweep_y[n]);
            chk("sweep_ych", a_ych, n);
            chk("sweep_valid", a_v, 1);
        end

        // Wide, non-power-of-two channel count
        for (int n = 0; n < 8; n++) begin
            c_s = cv[n].s; c_en = cv[n].en;
            tick();
            chk("wide_y", c_y, cv[n].y);
            chk("wide_ych", c_ych, cv[n].ych);
            chk("wide_valid", c_v, cv[n].v);
            chk("wide_wrap", c_wrap, 0);
        end

`ifdef MUX_SCAN_EN
        // Scan with mask 0x0005
        a_en = 0; tick();
        a_en = 1; a_mode = 1; a_mask = 16'h0005; a_i = 16'h0004;
        tick();
        chk("scan_entry_valid", a_v, 0);
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("scan_ych", a_ych, sc_ych[n]);
            chk("scan_wrap", a_wrap, sc_wrap[n]);
            chk("scan_valid", a_v, 1);
            chk("scan_y", a_y, sc_ych[n] == 2);
        end

        // Asynchronous reset while presenting channel 2
        found = 0;
        for (int n = 0; n < 8 && !found; n++) begin
            tick();
            if (a_ych == 4'd2) found = 1;
        end
        chk("reset_reach_ch2", found, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_y", a_y, 0);
        chk("async_reset_ych", a_ych, 0);
        chk("async_reset_valid", a_v, 0);
        chk("async_reset_wrap", a_wrap, 0);
        #2 rst = 1'b0;
        tick();
        chk("restart_entry_valid", a_v, 0);
        tick();
        chk("restart_ych", a_ych, 0);
        chk("restart_valid", a_v, 1);
        chk("restart_wrap", a_wrap, 0);

        // Mask edits on the DWELL=4 instance
        b_en = 1; b_mode = 1; b_mask = 16'h0000; b_i = 16'h0100;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("empty_valid", b_v, 0);
            chk("empty_wrap", b_wrap, 0);
        end
        b_mask = 16'h0100;
        tick();
        chk("mask_set_first_valid", b_v, 0);
        tick();
        chk("mask_set_ych", b_ych, 8);
        chk("mask_set_valid", b_v, 1);
        chk("mask_set_y", b_y, 1);
        b_mask = 16'h0000;
        tick();
        chk("mask_clear_valid", b_v, 0);
        chk("mask_clear_wrap", b_wrap, 0);
`else
        // Without the scan feature mode=1 selects exactly like mode=0
        a_en = 1; a_mode = 1; a_s = 4'd3; a_i = 16'h0008; a_mask = 16'hFFFF;
        tick();
        chk("noscan_y", a_y, 1);
        chk("noscan_ych", a_ych, 3);
        chk("noscan_valid", a_v, 1);
        chk("noscan_wrap", a_wrap, 0);
`endif

        // Randomized run against the behavioural model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        a_mask = 16'h0005;
        for (int n = 0; n < 600; n++) begin
            a_i    = 16'($urandom);
            a_s    = 4'($urandom);
            a_en   = ($urandom_range(0, 15) != 0);
            a_mode = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       a_mask = 16'h0000;
                    1:       a_mask = 16'h0001 << $urandom_range(0, 15);
                    2:       a_mask = 16'($urandom);
                    default: a_mask = 16'($urandom) & 16'($urandom);
                endcase
            end
            model_step();
            tick();
            chk("rand_y", a_y, m_y);
            chk("rand_ych", a_ych, m_ych);
            chk("rand_valid", a_v, m_v);
            chk("rand_wrap", a_wrap, m_w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_scan_nx1.md
Name: mux_scan_nx1

Overview:
- Parametrised N-channel, W-bit-wide registered multiplexer; successor to the fixed-width 2:1/4:1/8:1/16:1 structural mux family.
- Two modes:
  - Direct select: the external select input picks the channel.
  - Auto-scan: an internal pointer steps round-robin through enabled channels, holding each for a programmable number of cycles.
- Sits between a bank of sampled sources and a single serial consumer, e.g. a status monitor or test-bus probe.

Parameters:
- NCH, 16, number of input channels (2..64, power of two not required)
- W, 1, bits per channel
- SW, $clog2(NCH), select/pointer width (derived; do not override)
- DWELL, 1, cycles the scan pointer stays on each channel (1..255)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- i  input  NCH*W  packed channel data; channel k = i[k*W +: W]
- s  input  SW  direct-mode channel select
- mode  input  1  0 = direct, 1 = scan
- en  input  1  output enable; 0 forces idle
- ch_mask  input  NCH  scan-mode channel enables (1 = visit)
- y  output  W  registered selected data
- y_ch  output  SW  channel index that y came from
- y_valid  output  1  y/y_ch are meaningful this cycle
- wrap  output  1  one-cycle pulse when the scan pointer wraps to a lower index

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-high, on port rst.
  - Reset forces y=0, y_ch=0, y_valid=0, wrap=0, ptr=0, dwell_cnt=0, state=IDLE.
  - Reset is effective immediately, including mid-scan.
- States: IDLE, DIRECT, SCAN. Transitions are evaluated every cycle:
  - en=0 -> IDLE
  - en=1, mode=0 -> DIRECT
  - en=1, mode=1 -> SCAN
- IDLE:
  - y_valid=0, wrap=0.
  - y and y_ch hold their last values.
  - ptr and dwell_cnt are cleared.
- DIRECT:
  - Latency 1: y <= channel s, y_ch <= s, y_valid <= 1.
  - s >= NCH: y <= 0, y_ch <= s, y_valid <= 0.
- SCAN entry (from IDLE or DIRECT):
  - ptr loads the lowest-index set bit of ch_mask; dwell_cnt=0.
  - First scan output appears on the following edge.
- SCAN steady state:
  - Each cycle: y <= channel ptr, y_ch <= ptr, y_valid <= ch_mask[ptr].
  - dwell_cnt counts 0..DWELL-1.
  - At DWELL-1, ptr advances to the next set bit of ch_mask above ptr and dwell_cnt clears.
  - If no set bit lies above ptr, ptr wraps to the lowest set bit and wrap=1 for exactly that cycle, i.e. the cycle the new ptr is first presented on y_ch.
  - A single enabled channel: ptr stays put; wrap pulses every DWELL cycles.
- ch_mask changes:
  - If ch_mask[ptr] is cleared mid-dwell, ptr advances on the next edge regardless of dwell_cnt. y_valid=0 for that one cycle.
  - ch_mask==0: ptr holds, y_valid=0, wrap=0 until a bit is set. Then behave as SCAN entry.
- Mode change mid-dwell: takes effect next edge; no residual dwell state carried over.
- Outputs are registered only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: MUX_SCAN_EN.
- Defined:
  - Full behaviour above.
- Undefined:
  - Scan logic (ptr, dwell_cnt, wrap generation, ch_mask use) is not compiled.
  - mode=1 behaves exactly as mode=0.
  - wrap is tied 0.
  - ch_mask is ignored.
  - The DWELL parameter is unused.

Test Plan:
- Direct sweep: NCH=16, W=1, i=16'hB4F6, en=1, mode=0, s stepped 0..15 one per cycle -> y one cycle later = 0,1,1,0,1,1,1,1,0,0,1,0,1,1,0,1; y_ch=s; y_valid=1 throughout.
- Scan with mask: NCH=16, DWELL=2, ch_mask=16'h0005, mode=1 -> y_ch sequence 0,0,2,2,0,0,2,2...; wrap=1 only on each cycle y_ch returns to 0; y_valid=1.
- Mask edits: scanning ch_mask=16'h0000 -> y_valid=0, wrap=0 for 10 cycles; then set 16'h0100 -> y_ch=8 and y_valid=1 on the second edge after the write. Clear bit 8 mid-dwell (DWELL=4) -> y_valid=0 on the next cycle.
- Reset mid-scan: assert rst between clock edges during SCAN at y_ch=2 -> all outputs 0 immediately, before the next edge. Release rst with en=1, mode=1, ch_mask=16'h0005 -> scan restarts at channel 0.
- Wide and non-power-of-two: NCH=5, W=8, direct mode, s=4 -> y = i[39:32]. s=6 -> y=0, y_valid=0.
- Build without MUX_SCAN_EN: mode=1, s=3, i=16'h0008 -> y=1, y_ch=3, y_valid=1; wrap never asserts.
